vme64x_func_decoder: RTL and testbench
======================================

# vme64x_func_decoder

Simplified VME64x slave core between the VME bus front end and the SVEC carrier's internal Wishbone interconnect. It implements the CR/CSR registers that map VME functions: function ADERs, the WB32 register, and the BIT_SET/BIT_CLR module-enable bit. It decodes incoming single VME cycles by address modifier and ADER window. Accepted function accesses are forwarded as a single Wishbone transaction carrying the window-relative address.

## Interface
- g_func1_win_bits, default 19: function-1 window size is 2^g_func1_win_bits bytes. ADER compare uses address bits [23:g_func1_win_bits] for A24 and [31:g_func1_win_bits] for A32.
- g_wb_timeout, default 1023: cycles to wait for wb_ack_i before aborting with bus error.
- clk_sys_i, in, 1: system clock; the only clock.
- rst_i, in, 1: reset, synchronous and active-high.
- vme_stb_i, in, 1: one-cycle request strobe for a decoded, already-synchronised VME single cycle.
- vme_we_i, in, 1: 1 = write.
- vme_am_i, in, 6: address modifier.
- vme_addr_i, in, 32: byte address.
- vme_data_i, in, 32: write data. CSR byte accesses (D08 Byte3) use [7:0].
- vme_rdata_o, out, 32: read data, valid while vme_ack_o is high.
- vme_ack_o, out, 1: one-cycle completion pulse.
- vme_berr_o, out, 1: one-cycle bus-error pulse; replaces vme_ack_o.
- vme_busy_o, out, 1: high from acceptance until completion.
- wb_cyc_o, wb_stb_o, wb_we_o, out, 1 each: Wishbone master controls.
- wb_adr_o, out, 32: window-relative byte address.
- wb_dat_o, out, 32: Wishbone write data.
- wb_dat_i, in, 32: Wishbone read data.
- wb_ack_i, in, 1: Wishbone acknowledge.
- module_en_o, out, 1: BIT_SET bit 4.
- wb32_o, out, 1: WB32 register bit 0.

## Operation
- **CR/CSR space.** Selected when vme_am_i = 0x2F. The offset is vme_addr_i[18:0].
- **CSR registers** (8-bit, data in [7:0]):
  - ADERn byte k at 0x7FF63 + n·0x10 + 4·k, for n = 0,1 and k = 0..3 (MSB first).
  - WB32 at 0x7FF33.
  - BIT_SET at 0x7FFFB: writing 1 sets bits.
  - BIT_CLR at 0x7FFF7: writing 1 clears bits.
  - Reads of BIT_SET and BIT_CLR both return the bit register. Reads of ADER and WB32 return the stored value.
  - Any other CR/CSR offset reads 0x00 and ignores writes.
- **ADER format.** ADER = {base[31:8], AM[5:0], DFS, XAM}.
  - A function is disabled when ADER[0] = 1 or ADER[7:2] = 0.
  - Function 0 is A32 only. Function 1 accepts A24 or A32 according to its AM.
- **Function hit.** All of the following must hold:
  - module_en_o = 1;
  - function enabled;
  - vme_am_i equals ADER AM;
  - address bits above the window match the ADER base bits (A24 compares [23:win]).
  - Function 1 has priority over function 0.
- **Hit action.** Issue a Wishbone cycle with:
  - wb_adr_o = address with the window bits kept and upper bits zeroed;
  - wb_we_o = vme_we_i;
  - wb_dat_o = vme_data_i.
- **No hit.** A non-CR/CSR access that hits no function gets vme_berr_o one cycle after vme_stb_i.
- **FSM states:**
  - IDLE: on vme_stb_i, go to CSR, WB, or ERR.
  - CSR: performs the register access, then DONE.
  - WB: cyc/stb held until wb_ack_i or timeout.
  - DONE or ERR: one-cycle ack/berr pulse, then IDLE.
- vme_stb_i is ignored while vme_busy_o = 1.

## Timing
- **Reset values:** all outputs 0; ADERs 0; WB32 0; bit register 0.
- **CSR access:** request in cycle N, vme_ack_o in cycle N+1. Write data is visible on the register output in N+1.
- **Wishbone access:**
  - wb_cyc_o/wb_stb_o rise in N+1 and stay high through the cycle in which wb_ack_i is seen.
  - They drop the next cycle, together with vme_ack_o.
  - On reads, vme_rdata_o carries the wb_dat_i sampled at wb_ack.
- **Timeout:** if g_wb_timeout cycles elapse with cyc high and no ack, deassert cyc and pulse vme_berr_o.
- **Reset mid-transaction:** rst_i high mid-transaction aborts it with no ack; wb_cyc_o is low the cycle after.
- **BIT_CLR on bit 4:** clearing bit 4 disables function decoding from the next request on.

## Test plan
- Reset, then read ADER1 bytes -> all 0x00; module_en_o = 0; wb32_o = 0.
- Write ADER1 bytes 0x00, 0xC0, 0x00, 0xE4 (base 0xC00000, AM 0x39), ADER0 = 0x00000001, WB32 = 1, BIT_SET = 0x10 -> each write acked at N+1; read back ADER1 byte3 = 0xE4; module_en_o = 1.
- A24 (AM 0x39) write 0x10000000 to 0xC11000 -> wb_adr_o = 0x11000, wb_dat_o = 0x10000000; vme_ack_o one cycle after wb_ack_i.
- A24 write 0x00010000 to 0xC60224, then a read with wb_dat_i = 0x1234 -> wb_adr_o = 0x60224; vme_rdata_o = 0x1234.
- Each of the following gives vme_berr_o and no wb_cyc_o:
  - AM 0x39 access to 0xD00000;
  - AM 0x09 access to 0xC11000;
  - any access after BIT_CLR = 0x10.
- Hit with wb_ack_i held low -> vme_berr_o after g_wb_timeout cycles; next request is accepted normally.

Source files
------------

// File: rtl/vme64x_func_decoder.sv
// Simplified VME64x slave: CR/CSR function registers plus single-cycle decode of VME
// accesses into one window-relative Wishbone transaction per request.
module vme64x_func_decoder #(
    parameter int unsigned g_func1_win_bits = 19,
    parameter int unsigned g_wb_timeout     = 1023
) (
    input  logic        clk_sys_i,
    input  logic        rst_i,
    input  logic        vme_stb_i,
    input  logic        vme_we_i,
    input  logic [5:0]  vme_am_i,
    input  logic [31:0] vme_addr_i,
    input  logic [31:0] vme_data_i,
    output logic [31:0] vme_rdata_o,
    output logic        vme_ack_o,
    output logic        vme_berr_o,
    output logic        vme_busy_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        module_en_o,
    output logic        wb32_o
);

    typedef enum logic [2:0] {StIdle, StCsr, StWb, StDone, StErr} state_e;

    localparam logic [5:0]  CsrAm    = 6'h2f;
    localparam logic [31:0] WinMask  = (32'd1 << g_func1_win_bits) - 32'd1;
    localparam logic [31:0] HiMask32 = ~WinMask;
    localparam logic [31:0] HiMask24 = ~WinMask & 32'h00ff_ffff;
    localparam logic [31:0] TmoLast  = g_wb_timeout - 1;

    state_e      state_q, state_d;
    logic [31:0] ader0_q, ader1_q;
    logic [7:0]  wb32_q, bits_q;
    logic [31:0] tmo_q;
    logic [31:0] rdata_q;
    logic [31:0] wb_adr_q, wb_dat_q;
    logic        wb_we_q;

    logic [18:0] csr_off;
    logic [7:0]  csr_wdata, csr_rdata;
    logic        csr_sel, accept, csr_wr;
    logic        f0_en, f1_en, f1_a24, f0_hit, f1_hit, func_hit;
    logic [31:0] f1_mask;

    assign csr_off   = vme_addr_i[18:0];
    assign csr_wdata = vme_data_i[7:0];
    assign csr_sel   = (vme_am_i == CsrAm);
    assign accept    = (state_q == StIdle) && vme_stb_i;
    assign csr_wr    = accept && csr_sel && vme_we_i;

    // ADER = {base[31:8], AM[5:0], DFS, XAM}; XAM set or AM zero disables the function.
    // Function 0 only decodes A32 address modifiers (0x08-0x0F).
    assign f0_en   = !ader0_q[0] && (ader0_q[7:2] != 6'd0) && (ader0_q[7:5] == 3'b001);
    assign f1_en   = !ader1_q[0] && (ader1_q[7:2] != 6'd0);
    assign f1_a24  = (ader1_q[7:5] == 3'b111);
    assign f1_mask = f1_a24 ? HiMask24 : HiMask32;

    assign f0_hit = f0_en && (vme_am_i == ader0_q[7:2]) &&
                    ((vme_addr_i & HiMask32) == (ader0_q & HiMask32));
    assign f1_hit = f1_en && (vme_am_i == ader1_q[7:2]) &&
                    ((vme_addr_i & f1_mask) == (ader1_q & f1_mask));
    assign func_hit = !csr_sel && bits_q[4] && (f1_hit || f0_hit);

    always_comb begin
        csr_rdata = 8'h00;
        case (csr_off)
            19'h7ff63: csr_rdata = ader0_q[31:24];
            19'h7ff67: csr_rdata = ader0_q[23:16];
            19'h7ff6b: csr_rdata = ader0_q[15:8];
            19'h7ff6f: csr_rdata = ader0_q[7:0];
            19'h7ff73: csr_rdata = ader1_q[31:24];
            19'h7ff77: csr_rdata = ader1_q[23:16];
            19'h7ff7b: csr_rdata = ader1_q[15:8];
            19'h7ff7f: csr_rdata = ader1_q[7:0];
            19'h7ff33: csr_rdata = wb32_q;
            19'h7fffb,
            19'h7fff7: csr_rdata = bits_q;
            default:   csr_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            ader0_q <= '0;
            ader1_q <= '0;
            wb32_q  <= '0;
            bits_q  <= '0;
        end else if (csr_wr) begin
            case (csr_off)
                19'h7ff63: ader0_q[31:24] <= csr_wdata;
                19'h7ff67: ader0_q[23:16] <= csr_wdata;
                19'h7ff6b: ader0_q[15:8]  <= csr_wdata;
                19'h7ff6f: ader0_q[7:0]   <= csr_wdata;
                19'h7ff73: ader1_q[31:24] <= csr_wdata;
                19'h7ff77: ader1_q[23:16] <= csr_wdata;
                19'h7ff7b: ader1_q[15:8]  <= csr_wdata;
                19'h7ff7f: ader1_q[7:0]   <= csr_wdata;
                19'h7ff33: wb32_q         <= csr_wdata;
                19'h7fffb: bits_q         <= bits_q | csr_wdata;
                19'h7fff7: bits_q         <= bits_q & ~csr_wdata;
                default:   ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (vme_stb_i) begin
                    if (csr_sel) begin
                        state_d = StCsr;
                    end else if (func_hit) begin
                        state_d = StWb;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StWb: begin
                if (wb_ack_i) begin
                    state_d = StDone;
                end else if (tmo_q == TmoLast) begin
                    state_d = StErr;
                end
            end
            StCsr, StDone, StErr: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            tmo_q    <= '0;
            rdata_q  <= '0;
            wb_adr_q <= '0;
            wb_we_q  <= 1'b0;
            wb_dat_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StWb) begin
                tmo_q <= tmo_q + 32'd1;
            end else begin
                tmo_q <= '0;
            end
            // CSR registers are written at acceptance so the ack cycle already shows new data.
            if (accept && csr_sel) begin
                rdata_q <= {24'h0, csr_rdata};
            end
            if (accept && func_hit) begin
                wb_adr_q <= vme_addr_i & WinMask;
                wb_we_q  <= vme_we_i;
                wb_dat_q <= vme_data_i;
            end
            if ((state_q == StWb) && wb_ack_i) begin
                rdata_q <= wb_dat_i;
            end
        end
    end

    assign vme_rdata_o = rdata_q;
    assign vme_ack_o   = (state_q == StCsr) || (state_q == StDone);
    assign vme_berr_o  = (state_q == StErr);
    assign vme_busy_o  = (state_q != StIdle);
    assign wb_cyc_o    = (state_q == StWb);
    assign wb_stb_o    = (state_q == StWb);
    assign wb_we_o     = wb_we_q;
    assign wb_adr_o    = wb_adr_q;
    assign wb_dat_o    = wb_dat_q;
    assign module_en_o = bits_q[4];
    assign wb32_o      = wb32_q[0];

endmodule

// File: tb/tb_vme64x_func_decoder.sv
// Scoreboard bench for vme64x_func_decoder: a driver predicts each response from a
// register/window model and queues it; a negedge monitor compares DUT responses.
module tb_vme64x_func_decoder;

    localparam int unsigned WIN_BITS = 19;
    localparam int          TMO      = 16;
    localparam logic [5:0]  CSR_AM   = 6'h2f;

    typedef struct packed {
        logic        berr;
        logic        chk;
        logic [31:0] rdata;
        int          cycle;
    } resp_t;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
    } wb_t;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        vme_stb = 1'b0, vme_we = 1'b0;
    logic [5:0]  vme_am = '0;
    logic [31:0] vme_addr = '0, vme_data = '0;
    logic [31:0] vme_rdata, wb_adr, wb_dat_out;
    logic        vme_ack, vme_berr, vme_busy, wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_dat_in = '0;
    logic        wb_ack = 1'b0;
    logic        module_en, wb32;

    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc_cnt = 0;
    bit    cyc_prev = 1'b0;
    resp_t resp_q[$];
    wb_t   wb_q[$];

    logic [7:0] m_ader[2][4];
    logic [7:0] m_wb32, m_bits;

    vme64x_func_decoder #(
        .g_func1_win_bits(WIN_BITS),
        .g_wb_timeout    (TMO)
    ) dut (
        .clk_sys_i  (clk_sys),
        .rst_i      (rst),
        .vme_stb_i  (vme_stb),
        .vme_we_i   (vme_we),
        .vme_am_i   (vme_am),
        .vme_addr_i (vme_addr),
        .vme_data_i (vme_data),
        .vme_rdata_o(vme_rdata),
        .vme_ack_o  (vme_ack),
        .vme_berr_o (vme_berr),
        .vme_busy_o (vme_busy),
        .wb_cyc_o   (wb_cyc),
        .wb_stb_o   (wb_stb),
        .wb_we_o    (wb_we),
        .wb_adr_o   (wb_adr),
        .wb_dat_o   (wb_dat_out),
        .wb_dat_i   (wb_dat_in),
        .wb_ack_i   (wb_ack),
        .module_en_o(module_en),
        .wb32_o     (wb32)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic void model_reset();
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < 4; k++) m_ader[n][k] = 8'h00;
        end
        m_wb32 = 8'h00;
        m_bits = 8'h00;
    endfunction

    // Offsets: ADERn byte k at 0x7FF63 + 16n + 4k, WB32 0x7FF33, BIT_SET 0x7FFFB, BIT_CLR 0x7FFF7.
    function automatic logic [7:0] model_csr_read(input logic [31:0] addr);
        int unsigned off, rel;
        off = addr % 32'h0008_0000;
        rel = off - 32'h7ff63;
        if (off >= 32'h7ff63 && off <= 32'h7ff7f && rel % 4 == 0) return m_ader[rel / 16][(rel % 16) / 4];
        if (off == 32'h7ff33) return m_wb32;
        if (off == 32'h7fffb || off == 32'h7fff7) return m_bits;
        return 8'h00;
    endfunction

    function automatic void model_csr_write(input logic [31:0] addr, input logic [7:0] d);
        int unsigned off, rel;
        off = addr % 32'h0008_0000;
        rel = off - 32'h7ff63;
        if (off >= 32'h7ff63 && off <= 32'h7ff7f && rel % 4 == 0) m_ader[rel / 16][(rel % 16) / 4] = d;
        else if (off == 32'h7ff33) m_wb32 = d;
        else if (off == 32'h7fffb) m_bits = m_bits | d;
        else if (off == 32'h7fff7) m_bits = m_bits & ~d;
    endfunction

    function automatic bit model_hit(input logic [5:0] am, input logic [31:0] addr);
        longint unsigned a, f_am, win, adr;
        bit match;
        win = 64'd1 << WIN_BITS;
        adr = {32'h0, addr};
        if (((m_bits / 16) % 2) == 0) return 1'b0;
        for (int n = 1; n >= 0; n--) begin
            a = {32'h0, m_ader[n][0], m_ader[n][1], m_ader[n][2], m_ader[n][3]};
            f_am = (a / 4) % 64;
            if (a % 2 == 1 || f_am == 0) continue;
            if (n == 0 && (f_am < 8 || f_am > 15)) continue;
            if ({58'h0, am} != f_am) continue;
            if (f_am >= 56) match = ((adr % 64'h100_0000) / win) == ((a % 64'h100_0000) / win);
            else match = (adr / win) == (a / win);
            if (match) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (vme_busy && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        chk("busy_clears", {31'h0, vme_busy}, 32'h0);
    endtask

    // dly < 0: never acknowledge on Wishbone. poke: retry a CSR write while busy.
    task automatic do_access(input logic we, input logic [5:0] am, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] rdat, input int dly,
                             input bit poke);
        resp_t e;
        wb_t   w;
        int    e_cyc;
        bit    hit;
        e_cyc   = cyc_cnt + 1;
        hit     = 1'b0;
        e.chk   = !we;
        e.rdata = '0;
        if (am == CSR_AM) begin
            e.berr  = 1'b0;
            e.cycle = e_cyc;
            e.rdata = {24'h0, model_csr_read(addr)};
            if (we) model_csr_write(addr, data[7:0]);
        end else if (model_hit(am, addr)) begin
            hit   = 1'b1;
            w.adr = addr % (32'd1 << WIN_BITS);
            w.we  = we;
            w.dat = data;
            wb_q.push_back(w);
            if (dly < 0) begin
                e.berr  = 1'b1;
                e.chk   = 1'b0;
                e.cycle = e_cyc + TMO;
            end else begin
                e.berr  = 1'b0;
                e.cycle = e_cyc + dly + 1;
                e.rdata = rdat;
            end
        end else begin
            e.berr  = 1'b1;
            e.chk   = 1'b0;
            e.cycle = e_cyc;
        end
        resp_q.push_back(e);
        vme_we   = we;
        vme_am   = am;
        vme_addr = addr;
        vme_data = data;
        vme_stb  = 1'b1;
        @(negedge clk_sys);
        vme_stb = 1'b0;
        if (hit) begin
            chk("wb_cyc_next_cycle", {31'h0, wb_cyc}, 32'h1);
            if (dly >= 0) begin
                for (int i = 0; i < dly; i++) begin
                    if (poke && i == 0) begin
                        vme_am   = CSR_AM;
                        vme_we   = 1'b1;
                        vme_addr = 32'h0007_ff33;
                        vme_data = {24'h0, ~m_wb32};
                        vme_stb  = 1'b1;
                    end
                    @(negedge clk_sys);
                    vme_stb = 1'b0;
                end
                wb_ack    = 1'b1;
                wb_dat_in = rdat;
                @(negedge clk_sys);
                wb_ack = 1'b0;
            end
        end
        wait_idle();
        chk("module_en", {31'h0, module_en}, {31'h0, m_bits[4]});
        chk("wb32", {31'h0, wb32}, {31'h0, m_wb32[0]});
    endtask

    task automatic csr_wr(input logic [18:0] off, input logic [7:0] d);
        do_access(1'b1, CSR_AM, ($urandom & 32'hfff8_0000) | {13'h0, off},
                  {$urandom_range(0, 32'hff_ffff) , d}, 32'h0, 0, 1'b0);
    endtask

    task automatic csr_rd(input logic [18:0] off);
        do_access(1'b0, CSR_AM, ($urandom & 32'hfff8_0000) | {13'h0, off}, $urandom, 32'h0, 0, 1'b0);
    endtask

    function automatic logic [18:0] reg_off(input int unsigned idx);
        if (idx < 8) return 19'h7ff63 + 19'(idx * 4);
        if (idx == 8) return 19'h7ff33;
        if (idx == 9) return 19'h7fffb;
        if (idx == 10) return 19'h7fff7;
        return 19'($urandom);
    endfunction

    // Response and Wishbone-request monitor.
    always @(negedge clk_sys) begin
        resp_t e;
        wb_t   w;
        if (vme_ack || vme_berr) begin
            chk("resp_expected", {31'h0, resp_q.size() > 0}, 32'h1);
            if (resp_q.size() > 0) begin
                e = resp_q.pop_front();
                chk("resp_berr", {31'h0, vme_berr}, {31'h0, e.berr});
                chk("resp_ack_xor_berr", {31'h0, vme_ack & vme_berr}, 32'h0);
                chk("resp_cycle", cyc_cnt, e.cycle);
                if (e.chk) chk("vme_rdata", vme_rdata, e.rdata);
            end
        end
        if (wb_cyc && !cyc_prev) begin
            chk("wb_cyc_expected", {31'h0, wb_q.size() > 0}, 32'h1);
            if (wb_q.size() > 0) begin
                w = wb_q.pop_front();
                chk("wb_stb", {31'h0, wb_stb}, 32'h1);
                chk("wb_adr", wb_adr, w.adr);
                chk("wb_we", {31'h0, wb_we}, {31'h0, w.we});
                chk("wb_dat", wb_dat_out, w.dat);
            end
        end
        cyc_prev = wb_cyc;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [5:0]  am;
        model_reset();
        repeat (3) @(negedge clk_sys);
        chk("rst_ack", {31'h0, vme_ack}, 32'h0);
        chk("rst_berr", {31'h0, vme_berr}, 32'h0);
        chk("rst_busy", {31'h0, vme_busy}, 32'h0);
        chk("rst_cyc", {31'h0, wb_cyc}, 32'h0);
        chk("rst_stb", {31'h0, wb_stb}, 32'h0);
        chk("rst_we", {31'h0, wb_we}, 32'h0);
        chk("rst_adr", wb_adr, 32'h0);
        chk("rst_dat", wb_dat_out, 32'h0);
        chk("rst_rdata", vme_rdata, 32'h0);
        chk("rst_module_en", {31'h0, module_en}, 32'h0);
        chk("rst_wb32", {31'h0, wb32}, 32'h0);
        rst = 1'b0;
        @(negedge clk_sys);

        for (int k = 0; k < 4; k++) csr_rd(19'h7ff73 + 19'(k * 4));
        csr_wr(19'h7ff73, 8'h00);
        csr_wr(19'h7ff77, 8'hc0);
        csr_wr(19'h7ff7b, 8'h00);
        csr_wr(19'h7ff7f, 8'he4);
        csr_wr(19'h7ff63, 8'h00);
        csr_wr(19'h7ff67, 8'h00);
        csr_wr(19'h7ff6b, 8'h00);
        csr_wr(19'h7ff6f, 8'h01);
        csr_wr(19'h7ff33, 8'h01);
        csr_wr(19'h7fffb, 8'h10);
        csr_rd(19'h7ff7f);
        csr_rd(19'h7fffb);
        csr_rd(19'h7fff7);
        csr_rd(19'h7ff33);

        do_access(1'b1, 6'h39, 32'h00c1_1000, 32'h1000_0000, 32'h0, 2, 1'b0);
        do_access(1'b1, 6'h39, 32'h00c6_0224, 32'h0001_0000, 32'h0, 0, 1'b0);
        do_access(1'b0, 6'h39, 32'h00c6_0224, $urandom, 32'h0000_1234, 1, 1'b0);
        do_access(1'b1, 6'h39, 32'h00d0_0000, $urandom, 32'h0, 0, 1'b0);
        do_access(1'b0, 6'h09, 32'h00c1_1000, $urandom, 32'h0, 0, 1'b0);
        do_access(1'b0, 6'h39, 32'h00c0_0010, $urandom, $urandom, -1, 1'b0);
        do_access(1'b1, 6'h39, 32'h00c0_0020, $urandom, 32'h0, 0, 1'b0);
        do_access(1'b0, 6'h39, 32'h00c2_0000, $urandom, $urandom, 4, 1'b1);
        csr_wr(19'h7fff7, 8'h10);
        do_access(1'b1, 6'h39, 32'h00c1_1000, $urandom, 32'h0, 0, 1'b0);
        csr_wr(19'h7fffb, 8'h10);
        // Function 0 as A32 window at 0x40000000, AM 0x09.
        csr_wr(19'h7ff63, 8'h40);
        csr_wr(19'h7ff6f, 8'h24);

        for (int i = 0; i < 250; i++) begin
            int unsigned sel;
            int          d;
            logic        w;
            sel = $urandom_range(0, 9);
            w   = 1'($urandom_range(0, 1));
            d   = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 4));
            am  = 6'h39;
            a   = $urandom;
            case (sel)
                0: begin
                    if ($urandom_range(0, 1) == 1) csr_wr(19'h7fffb, 8'h10 | 8'($urandom));
                    else if ($urandom_range(0, 3) == 0) csr_wr(19'h7fff7, 8'($urandom));
                    else csr_wr(19'h7fff7, 8'($urandom) & 8'hef);
                end
                1: csr_wr(19'h7ff33, 8'($urandom));
                2: csr_rd(reg_off($urandom_range(0, 11)));
                3: do_access(w, CSR_AM, a, $urandom, 32'h0, 0, 1'b0);
                default: begin
                    if (sel <= 6) begin
                        a = {8'($urandom), 24'h0} | (32'h00c0_0000 + $urandom_range(0, 32'h000f_ffff));
                    end else if (sel <= 8) begin
                        am = 6'h09;
                        a  = 32'h4000_0000 + $urandom_range(0, 32'h000f_ffff);
                    end else begin
                        case ($urandom_range(0, 3))
                            0: am = 6'h39;
                            1: am = 6'h3d;
                            2: am = 6'h09;
                            default: am = 6'h0d;
                        endcase
                    end
                    do_access(w, am, a, $urandom, $urandom, d, $urandom_range(0, 7) == 0);
                end
            endcase
        end

        // Reset in the middle of a Wishbone cycle: no completion, cyc low right after.
        csr_wr(19'h7fffb, 8'h10);
        if (model_hit(6'h39, 32'h00c1_1000)) begin
            wb_q.push_back('{adr: 32'h0001_1000, we: 1'b0, dat: 32'h5a5a_0001});
        end
        vme_we   = 1'b0;
        vme_am   = 6'h39;
        vme_addr = 32'h00c1_1000;
        vme_data = 32'h5a5a_0001;
        vme_stb  = 1'b1;
        @(negedge clk_sys);
        vme_stb = 1'b0;
        repeat (3) @(negedge clk_sys);
        rst = 1'b1;
        @(negedge clk_sys);
        rst = 1'b0;
        model_reset();
        chk("rst_mid_cyc", {31'h0, wb_cyc}, 32'h0);
        chk("rst_mid_busy", {31'h0, vme_busy}, 32'h0);
        chk("rst_mid_module_en", {31'h0, module_en}, 32'h0);
        repeat (4) @(negedge clk_sys);
        for (int k = 0; k < 4; k++) csr_rd(19'h7ff73 + 19'(k * 4));
        do_access(1'b1, 6'h39, 32'h00c1_1000, $urandom, 32'h0, 0, 1'b0);

        repeat (5) @(negedge clk_sys);
        chk("resp_q_drained", resp_q.size(), 32'h0);
        chk("wb_q_drained", wb_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
